// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan controller.
//   ADC_NUM      : channels handled (fixed to the scanner's port packing)
//   DATA_W       : ADC sample width
//   adc_word_t   : one ADC sample / average
//   scan_state_t : scanner sequencing states
//   popcount8    : number of set bits in an 8-bit vector
package adc_pkg;

  localparam int unsigned ADC_NUM = 8;
  localparam int unsigned DATA_W  = 10;

  typedef logic [DATA_W-1:0] adc_word_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    RESTART
  } scan_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/adc_ch_avg.sv
// One channel of the scan controller: accumulates 2^AVG_LOG good samples, publishes the
// truncated mean with a one-cycle valid strobe, and keeps sticky hi/lo threshold alarms.
//   clk, aclr     : clock, asynchronous active-high reset
//   clr_i         : drop any partial sum (scanner not in RUN)
//   accept_i      : a good (enabled, error-free) sample is present this cycle
//   data_i        : sample value
//   thr_hi_i/lo_i : alarm thresholds (strict compares)
//   alarm_clr_i   : clear sticky alarms (a coincident set wins)
//   avg_o         : latest average
//   avg_valid_o   : one-cycle strobe, avg_o just updated
//   alarm_hi_o/lo_o : sticky alarms
module adc_ch_avg
  import adc_pkg::*;
#(
  parameter int unsigned AVG_LOG = 2
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              clr_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] thr_hi_i,
  input  logic [DATA_W-1:0] thr_lo_i,
  input  logic              alarm_clr_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o,
  output logic              alarm_hi_o,
  output logic              alarm_lo_o
);

  localparam int unsigned SumW = DATA_W + AVG_LOG;
  localparam int unsigned CntW = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG) - 1);

  logic [SumW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  adc_word_t         avg_q, avg_d;
  logic              valid_q, valid_d;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;
  logic [SumW-1:0]   sum;
  adc_word_t         new_avg;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    hi_d    = alarm_clr_i ? 1'b0 : hi_q;
    lo_d    = alarm_clr_i ? 1'b0 : lo_q;
    // Sum of 2^AVG_LOG samples always fits in DATA_W+AVG_LOG bits.
    sum     = acc_q + SumW'(data_i);
    new_avg = adc_word_t'(sum >> AVG_LOG);

    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      if (cnt_q == CntLast) begin
        avg_d   = new_avg;
        valid_d = 1'b1;
        if (new_avg > thr_hi_i) hi_d = 1'b1;
        if (new_avg < thr_lo_i) lo_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = valid_q;
  assign alarm_hi_o  = hi_q;
  assign alarm_lo_o  = lo_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Sequences and supervises the free-running 8-channel MCP3008 scanner: drives its sclr,
// watchdogs it for stalled sample strobes, and averages/alarms each channel.
//   clk, aclr    : clock, asynchronous active-high reset
//   run_i        : level, scanning enabled
//   ch_ena_i     : per-channel accept mask
//   thr_hi_i/lo_i: shared alarm thresholds
//   alarm_clr_i  : clears alarms, timeout and err_cnt
//   adc_data_i/adc_err_i/adc_sample_i : scanner sample values, error flags, strobes
//   adc_sclr_o   : synchronous clear to the scanner
//   avg_o/avg_valid_o : per-channel average and update strobe
//   alarm_hi_o/alarm_lo_o : sticky threshold alarms
//   err_cnt_o    : saturating count of discarded error samples
//   timeout_o    : sticky, watchdog has fired
//   busy_o       : not idle
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned AVG_LOG     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned RESTART_CYC = 16
) (
  input  logic                            clk,
  input  logic                            aclr,
  input  logic                            run_i,
  input  logic [ADC_NUM-1:0]              ch_ena_i,
  input  logic [DATA_W-1:0]               thr_hi_i,
  input  logic [DATA_W-1:0]               thr_lo_i,
  input  logic                            alarm_clr_i,
  input  logic [ADC_NUM-1:0][DATA_W-1:0]  adc_data_i,
  input  logic [ADC_NUM-1:0]              adc_err_i,
  input  logic [ADC_NUM-1:0]              adc_sample_i,
  output logic                            adc_sclr_o,
  output logic [ADC_NUM-1:0][DATA_W-1:0]  avg_o,
  output logic [ADC_NUM-1:0]              avg_valid_o,
  output logic [ADC_NUM-1:0]              alarm_hi_o,
  output logic [ADC_NUM-1:0]              alarm_lo_o,
  output logic [15:0]                     err_cnt_o,
  output logic                            timeout_o,
  output logic                            busy_o
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RsW = $clog2(RESTART_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);
  localparam logic [RsW-1:0] RsLast = RsW'(RESTART_CYC - 1);

  scan_state_t        state_q, state_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [RsW-1:0]     rs_q, rs_d;
  logic               sclr_q, sclr_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        err_q, err_d;
  logic               fire;
  logic               in_run;
  logic [ADC_NUM-1:0] accept;
  logic [ADC_NUM-1:0] err_hits;
  logic [15:0]        err_base;
  logic [16:0]        err_sum;

  // Sequencer and watchdog.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    rs_d    = rs_q;
    fire    = 1'b0;

    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        rs_d = '0;
        if (run_i) state_d = START;
      end
      START: begin
        wd_d    = '0;
        rs_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        // Any strobe proves the scanner is alive, regardless of the accept mask.
        if (|adc_sample_i) begin
          wd_d = '0;
        end else if (wd_q == WdLast) begin
          fire    = 1'b1;
          wd_d    = '0;
          rs_d    = '0;
          state_d = RESTART;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      RESTART: begin
        wd_d = '0;
        if (rs_q == RsLast) begin
          rs_d    = '0;
          state_d = RUN;
        end else begin
          rs_d = rs_q + RsW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!run_i) begin
      state_d = IDLE;
      wd_d    = '0;
      rs_d    = '0;
      fire    = 1'b0;
    end

    // Registered outputs are decoded from the next state so they track state_q exactly.
    sclr_d    = (state_d == IDLE) || (state_d == RESTART);
    busy_d    = (state_d != IDLE);
    timeout_d = fire | (timeout_q & ~alarm_clr_i);
  end

  // Sample routing and error counting.
  always_comb begin
    in_run   = (state_q == RUN);
    accept   = in_run ? (adc_sample_i & ch_ena_i & ~adc_err_i) : '0;
    err_hits = in_run ? (adc_sample_i & ch_ena_i & adc_err_i) : '0;
    err_base = alarm_clr_i ? 16'h0000 : err_q;
    err_sum  = {1'b0, err_base} + 17'(popcount8(err_hits));
    err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      rs_q      <= '0;
      sclr_q    <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      rs_q      <= rs_d;
      sclr_q    <= sclr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  for (genvar g = 0; g < ADC_NUM; g++) begin : g_ch
    adc_ch_avg #(
      .AVG_LOG(AVG_LOG)
    ) u_ch (
      .clk        (clk),
      .aclr       (aclr),
      .clr_i      (~in_run),
      .accept_i   (accept[g]),
      .data_i     (adc_data_i[g]),
      .thr_hi_i   (thr_hi_i),
      .thr_lo_i   (thr_lo_i),
      .alarm_clr_i(alarm_clr_i),
      .avg_o      (avg_o[g]),
      .avg_valid_o(avg_valid_o[g]),
      .alarm_hi_o (alarm_hi_o[g]),
      .alarm_lo_o (alarm_lo_o[g])
    );
  end

  assign adc_sclr_o = sclr_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: directed scenarios plus a randomized phase, with a
// per-channel scoreboard of expected averages filled by a behavioural model.
module tb_adc_scan_ctrl;

  localparam int AvgLog = 2;
  localparam int AvgN   = 1 << AvgLog;

  logic            clk = 1'b0;
  logic            aclr;
  logic            run;
  logic [7:0]      ch_ena;
  logic [9:0]      thr_hi, thr_lo;
  logic            alarm_clr;
  logic [7:0][9:0] adc_data;
  logic [7:0]      adc_err, adc_sample;
  logic            adc_sclr_o;
  logic [7:0][9:0] avg_o;
  logic [7:0]      avg_valid_o, alarm_hi_o, alarm_lo_o;
  logic [15:0]     err_cnt_o;
  logic            timeout_o, busy_o;

  adc_scan_ctrl #(
    .AVG_LOG    (AvgLog),
    .TIMEOUT_CYC(4096),
    .RESTART_CYC(16)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .run_i       (run),
    .ch_ena_i    (ch_ena),
    .thr_hi_i    (thr_hi),
    .thr_lo_i    (thr_lo),
    .alarm_clr_i (alarm_clr),
    .adc_data_i  (adc_data),
    .adc_err_i   (adc_err),
    .adc_sample_i(adc_sample),
    .adc_sclr_o  (adc_sclr_o),
    .avg_o       (avg_o),
    .avg_valid_o (avg_valid_o),
    .alarm_hi_o  (alarm_hi_o),
    .alarm_lo_o  (alarm_lo_o),
    .err_cnt_o   (err_cnt_o),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural model: list of good samples per channel, sticky alarms, error total.
  typedef struct packed {
    logic [9:0]  avg;
    logic        hi;
    logic        lo;
    logic [31:0] due;
  } exp_t;

  exp_t        exp_q[8][$];
  int unsigned m_sum[8];
  int          m_n[8];
  bit          m_hi[8];
  bit          m_lo[8];
  int unsigned m_err;
  bit          m_run;

  function automatic void model_clear_partials();
    for (int i = 0; i < 8; i++) begin
      m_sum[i] = 0;
      m_n[i]   = 0;
    end
  endfunction

  // Inputs currently driven will be consumed at the next rising edge.
  function automatic void model_cycle();
    exp_t e;
    int unsigned a;
    if (alarm_clr) begin
      m_err = 0;
      for (int i = 0; i < 8; i++) begin
        m_hi[i] = 0;
        m_lo[i] = 0;
      end
    end
    if (m_run) begin
      for (int i = 0; i < 8; i++) begin
        if (adc_sample[i] && ch_ena[i]) begin
          if (adc_err[i]) begin
            if (m_err < 65535) m_err++;
          end else begin
            m_sum[i] += adc_data[i];
            m_n[i]++;
            if (m_n[i] == AvgN) begin
              a = m_sum[i] / AvgN;
              if (a > thr_hi) m_hi[i] = 1;
              if (a < thr_lo) m_lo[i] = 1;
              e.avg = 10'(a);
              e.hi  = m_hi[i];
              e.lo  = m_lo[i];
              e.due = cyc + 1;
              exp_q[i].push_back(e);
              m_sum[i] = 0;
              m_n[i]   = 0;
            end
          end
        end
      end
    end
  endfunction

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    adc_sample = '0;
    adc_err    = '0;
    alarm_clr  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_alarm_hi%0d", tag, i), alarm_hi_o[i], m_hi[i]);
      chk($sformatf("%s_alarm_lo%0d", tag, i), alarm_lo_o[i], m_lo[i]);
    end
    chk({tag, "_err_cnt"}, err_cnt_o, m_err);
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
    chk("start_sclr_low", adc_sclr_o, 0);
    chk("start_busy", busy_o, 1);
    step();
    m_run = 1'b1;
  endtask

  task automatic stop_run();
    run = 1'b0;
    step();
    m_run = 1'b0;
    model_clear_partials();
    chk("idle_sclr_high", adc_sclr_o, 1);
    chk("idle_busy", busy_o, 0);
  endtask

  // Monitor: every avg_valid strobe must match the next expected average for that channel.
  always @(negedge clk) begin
    if (!aclr) begin
      for (int i = 0; i < 8; i++) begin
        if (avg_valid_o[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid ch%0d got avg=%0d want no strobe", i, avg_o[i]);
          end else begin
            exp_t e;
            e = exp_q[i].pop_front();
            chk($sformatf("sb_avg_ch%0d", i), avg_o[i], e.avg);
            chk($sformatf("sb_hi_ch%0d", i), alarm_hi_o[i], e.hi);
            chk($sformatf("sb_lo_ch%0d", i), alarm_lo_o[i], e.lo);
            chk($sformatf("sb_latency_ch%0d", i), cyc, e.due);
          end
        end
      end
    end
  end

  int  low_cnt, high_cnt;
  bit  sclr_seen;

  initial begin
    aclr       = 1'b1;
    run        = 1'b0;
    ch_ena     = 8'hFF;
    thr_hi     = 10'd1023;
    thr_lo     = 10'd0;
    alarm_clr  = 1'b0;
    adc_data   = '0;
    adc_err    = '0;
    adc_sample = '0;
    m_err      = 0;
    m_run      = 0;
    for (int i = 0; i < 8; i++) begin
      m_hi[i] = 0;
      m_lo[i] = 0;
    end
    model_clear_partials();
    repeat (3) @(posedge clk);
    #1;
    aclr = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    chk("rst_sclr", adc_sclr_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_avg", avg_o, 0);
    chk("rst_valid", avg_valid_o, 0);
    chk("rst_timeout", timeout_o, 0);
    check_state("rst");

    // 1: ch3 averages 100..103 -> 101, strobe exactly one cycle after the 4th sample.
    start_run();
    for (int k = 0; k < 4; k++) begin
      adc_sample  = 8'h08;
      adc_data[3] = 10'(100 + k);
      step();
    end
    chk("t1_valid", avg_valid_o, 8'h08);
    chk("t1_avg3", avg_o[3], 101);
    step();
    chk("t1_valid_pulse", avg_valid_o, 0);

    // 2: ch5 at full scale raises alarm_hi; clr coincident with a set keeps it.
    thr_hi = 10'd1000;
    for (int k = 0; k < 4; k++) begin
      adc_sample  = 8'h20;
      adc_data[5] = 10'd1023;
      step();
    end
    step();
    chk("t2_hi_set", alarm_hi_o[5], 1);
    for (int k = 0; k < 4; k++) begin
      adc_sample  = 8'h20;
      adc_data[5] = 10'd1023;
      alarm_clr   = (k == 3);
      step();
    end
    chk("t2_hi_set_wins", alarm_hi_o[5], 1);
    alarm_clr = 1'b1;
    step();
    chk("t2_hi_cleared", alarm_hi_o[5], 0);
    check_state("t2");

    // 3: error samples are counted, never averaged; counter saturates.
    for (int k = 0; k < 3; k++) begin
      adc_sample = 8'h03;
      adc_err    = 8'h03;
      step();
    end
    chk("t3_err6", err_cnt_o, 6);
    alarm_clr = 1'b1;
    step();
    chk("t3_err_clr", err_cnt_o, 0);
    for (int k = 0; k < 8191; k++) begin
      adc_sample = 8'hFF;
      adc_err    = 8'hFF;
      step();
    end
    adc_sample = 8'h3F;
    adc_err    = 8'h3F;
    step();
    chk("t3_err_fffe", err_cnt_o, 16'hFFFE);
    adc_sample = 8'h03;
    adc_err    = 8'h03;
    step();
    chk("t3_err_sat", err_cnt_o, 16'hFFFF);
    adc_sample = 8'h07;
    adc_err    = 8'h07;
    step();
    chk("t3_err_hold", err_cnt_o, 16'hFFFF);
    check_state("t3");
    alarm_clr = 1'b1;
    step();

    // 5: run drop discards the partial average on ch2.
    thr_hi = 10'd1023;
    for (int k = 0; k < 2; k++) begin
      adc_sample  = 8'h04;
      adc_data[2] = 10'(500 + 100 * k);
      step();
    end
    stop_run();
    start_run();
    for (int k = 0; k < 4; k++) begin
      adc_sample  = 8'h04;
      adc_data[2] = 10'd8;
      step();
    end
    chk("t5_avg2", avg_o[2], 8);

    // 4: watchdog fires after TIMEOUT_CYC RUN cycles without a strobe.
    stop_run();
    run = 1'b1;
    step();
    m_run   = 1'b1;
    low_cnt = 1;
    while (!adc_sclr_o && low_cnt < 6000) begin
      step();
      if (!adc_sclr_o) low_cnt++;
    end
    chk("t4_cycles_to_restart", low_cnt, 4097);
    chk("t4_timeout_set", timeout_o, 1);
    chk("t4_busy_restart", busy_o, 1);
    high_cnt = 1;
    while (adc_sclr_o && high_cnt < 100) begin
      step();
      if (adc_sclr_o) high_cnt++;
    end
    chk("t4_restart_len", high_cnt, 16);
    chk("t4_back_busy", busy_o, 1);
    alarm_clr = 1'b1;
    step();
    chk("t4_timeout_clr", timeout_o, 0);
    sclr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 1367; j++) begin
        step();
        if (adc_sclr_o) sclr_seen = 1;
      end
      // Masked strobe still feeds the watchdog.
      ch_ena     = 8'h00;
      adc_sample = 8'h10;
      step();
      ch_ena = 8'hFF;
    end
    chk("t4_no_restart", sclr_seen, 0);
    chk("t4_no_timeout", timeout_o, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        thr_hi = 10'($urandom_range(1023, 500));
        thr_lo = 10'($urandom_range(600, 0));
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(19) == 0) ch_ena[i] = ~ch_ena[i];
        adc_sample[i] = ($urandom_range(99) < 40);
        adc_err[i]    = ($urandom_range(7) == 0);
        adc_data[i]   = 10'($urandom_range(1023));
      end
      alarm_clr = ($urandom_range(49) == 0);
      step();
    end
    step();
    step();
    check_state("rand");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sb_drained_ch%0d", i), exp_q[i].size(), 0);
    end

    // 6: asynchronous reset mid-RUN.
    @(posedge clk);
    #3;
    aclr = 1'b1;
    run  = 1'b0;
    #1;
    chk("t6_sclr", adc_sclr_o, 1);
    chk("t6_busy", busy_o, 0);
    chk("t6_avg", avg_o, 0);
    chk("t6_valid", avg_valid_o, 0);
    chk("t6_hi", alarm_hi_o, 0);
    chk("t6_lo", alarm_lo_o, 0);
    chk("t6_err", err_cnt_o, 0);
    chk("t6_timeout", timeout_o, 0);
    m_run = 0;
    m_err = 0;
    for (int i = 0; i < 8; i++) begin
      m_hi[i] = 0;
      m_lo[i] = 0;
      exp_q[i].delete();
    end
    model_clear_partials();
    @(posedge clk);
    #1;
    aclr = 1'b0;
    step();
    chk("t6_post_sclr", adc_sclr_o, 1);
    chk("t6_post_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
